// File: rtl/boxcar_decimator.sv
// Boxcar average-and-decimate: sums 2**AvgBits signed samples and emits one registered mean per block.
// Optional macro BOXCAR_ROUND_EN: round half toward +inf with positive saturation instead of truncation.
module boxcar_decimator #(
    parameter int DataWidth = 24,
    parameter int AvgBits   = 4
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 in_tvalid,
    output logic                 in_tready,
    input  logic [DataWidth-1:0] in_tdata,
    output logic                 out_tvalid,
    input  logic                 out_tready,
    output logic [DataWidth-1:0] out_tdata
);
    localparam int AccW = DataWidth + AvgBits;
    localparam int CntW = (AvgBits > 0) ? AvgBits : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'((1 << AvgBits) - 1);

    logic signed [AccW-1:0] acc;
    logic signed [AccW-1:0] sum;
    logic [CntW-1:0]        count;
    logic                   last;
    logic                   accept;
    logic [DataWidth-1:0]   result;

    // Only the closing sample of a block needs the output register free.
    assign last      = (count == LastCnt);
    assign in_tready = ~out_tvalid | out_tready | ~last;
    assign accept    = in_tvalid & in_tready;
    assign sum       = acc + AccW'($signed(in_tdata));

`ifdef BOXCAR_ROUND_EN
    generate
        if (AvgBits > 0) begin : g_round
            // floor((s + 2**(A-1)) / 2**A) equals floor(s / 2**A) + s[A-1]
            logic [DataWidth:0] rounded;
            assign rounded = {sum[AccW-1], sum[AccW-1:AvgBits]}
                           + (DataWidth+1)'(sum[AvgBits-1]);
            assign result  = (~rounded[DataWidth] & rounded[DataWidth-1])
                           ? {1'b0, {(DataWidth-1){1'b1}}}
                           : rounded[DataWidth-1:0];
        end else begin : g_pass
            assign result = sum[DataWidth-1:0];
        end
    endgenerate
`else
    assign result = sum[AccW-1:AvgBits];
`endif

    always_ff @(posedge aclk) begin
        if (areset) begin
            acc        <= '0;
            count      <= '0;
            out_tvalid <= 1'b0;
            out_tdata  <= '0;
        end else begin
            if (out_tvalid && out_tready) begin
                out_tvalid <= 1'b0;
            end
            if (accept) begin
                if (last) begin
                    acc        <= '0;
                    count      <= '0;
                    out_tvalid <= 1'b1;
                    out_tdata  <= result;
                end else begin
                    acc   <= sum;
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_boxcar_decimator.sv
// Self-checking bench for boxcar_decimator: directed cases on a 4-sample instance, randomized
// streams on 4-sample and pass-through instances against a queue-based reference.
module tb_boxcar_decimator;
    localparam int DW = 24;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic          areset;
    logic          a_iv, a_ir, a_ov, a_or;
    logic [DW-1:0] a_id, a_od;
    logic          b_iv, b_ir, b_ov, b_or;
    logic [DW-1:0] b_id, b_od;

    boxcar_decimator #(.DataWidth(DW), .AvgBits(2)) dut_a (
        .aclk(aclk), .areset(areset),
        .in_tvalid(a_iv), .in_tready(a_ir), .in_tdata(a_id),
        .out_tvalid(a_ov), .out_tready(a_or), .out_tdata(a_od)
    );

    boxcar_decimator #(.DataWidth(DW), .AvgBits(0)) dut_b (
        .aclk(aclk), .areset(areset),
        .in_tvalid(b_iv), .in_tready(b_ir), .in_tdata(b_id),
        .out_tvalid(b_ov), .out_tready(b_or), .out_tdata(b_od)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    longint        blk_sum = 0;
    int            blk_n   = 0;

    // Mean of four samples given their exact integer sum.
    function automatic logic [DW-1:0] avg4(input longint s);
        longint r;
`ifdef BOXCAR_ROUND_EN
        r = (s + 2) >>> 2;
        if (r > 64'sd8388607) r = 64'sd8388607;
`else
        r = s >>> 2;
`endif
        return r[DW-1:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic put_a(input logic [DW-1:0] d, input logic exp_rdy, input string tag);
        a_iv = 1'b1;
        a_id = d;
        #1;
        chk(tag, {31'd0, a_ir}, {31'd0, exp_rdy});
        step();
        a_iv = 1'b0;
    endtask

    task automatic out_check();
        if (a_ov && a_or) begin
            chk("rnd_a_pending", {31'd0, qa.size() != 0}, 32'd1);
            if (qa.size() != 0) chk("rnd_a_data", {8'd0, a_od}, {8'd0, qa.pop_front()});
        end
        if (b_ov && b_or) begin
            chk("rnd_b_pending", {31'd0, qb.size() != 0}, 32'd1);
            if (qb.size() != 0) chk("rnd_b_data", {8'd0, b_od}, {8'd0, qb.pop_front()});
        end
    endtask

    initial begin
        areset = 1'b1;
        a_iv = 1'b1; a_id = 24'd77; a_or = 1'b1;
        b_iv = 1'b1; b_id = 24'd55; b_or = 1'b1;
        step();
        step();
        chk("rst_ov", {31'd0, a_ov}, 32'd0);
        chk("rst_od", {8'd0, a_od}, 32'd0);
        chk("rst_rdy", {31'd0, a_ir}, 32'd1);
        chk("rst_b_ov", {31'd0, b_ov}, 32'd0);
        areset = 1'b0;
        a_iv = 1'b0; b_iv = 1'b0;
        step();
        chk("post_rst_ov", {31'd0, a_ov}, 32'd0);

        // 4,8,12,16 back to back -> 10
        put_a(24'd4, 1'b1, "t1_rdy0");
        chk("t1_nov0", {31'd0, a_ov}, 32'd0);
        put_a(24'd8, 1'b1, "t1_rdy1");
        put_a(24'd12, 1'b1, "t1_rdy2");
        chk("t1_nov2", {31'd0, a_ov}, 32'd0);
        put_a(24'd16, 1'b1, "t1_rdy3");
        chk("t1_ov", {31'd0, a_ov}, 32'd1);
        chk("t1_od", {8'd0, a_od}, 32'd10);
        step();
        chk("t1_drop", {31'd0, a_ov}, 32'd0);

        // negative floor / rounding
        put_a(-24'sd1, 1'b1, "t2_rdy0");
        put_a(-24'sd2, 1'b1, "t2_rdy1");
        put_a(-24'sd3, 1'b1, "t2_rdy2");
        put_a(-24'sd4, 1'b1, "t2_rdy3");
        chk("t2_ov", {31'd0, a_ov}, 32'd1);
        chk("t2_od", {8'd0, a_od}, {8'd0, avg4(-64'sd10)});
        step();

        // backpressure: second block's final sample stalls until the first result leaves
        a_or = 1'b0;
        for (int i = 0; i < 4; i++) put_a(24'd5, 1'b1, "t3_rdy_first");
        chk("t3_ov1", {31'd0, a_ov}, 32'd1);
        chk("t3_od1", {8'd0, a_od}, 32'd5);
        for (int i = 0; i < 3; i++) put_a(24'd5, 1'b1, "t3_rdy_second");
        chk("t3_hold_ov", {31'd0, a_ov}, 32'd1);
        a_iv = 1'b1; a_id = 24'd5;
        #1;
        chk("t3_stall", {31'd0, a_ir}, 32'd0);
        step();
        chk("t3_stall2", {31'd0, a_ir}, 32'd0);
        chk("t3_hold_od", {8'd0, a_od}, 32'd5);
        a_or = 1'b1;
        #1;
        chk("t3_release", {31'd0, a_ir}, 32'd1);
        step();
        a_or = 1'b0; a_iv = 1'b0;
        #1;
        chk("t3_ov2", {31'd0, a_ov}, 32'd1);
        chk("t3_od2", {8'd0, a_od}, 32'd5);
        a_or = 1'b1;
        step();
        chk("t3_drain", {31'd0, a_ov}, 32'd0);

        // extremes do not wrap
        for (int i = 0; i < 4; i++) put_a(24'h7FFFFF, 1'b1, "t4_rdy_max");
        chk("t4_max", {8'd0, a_od}, 32'h7FFFFF);
        for (int i = 0; i < 4; i++) put_a(24'h800000, 1'b1, "t4_rdy_min");
        chk("t4_min", {8'd0, a_od}, 32'h800000);
        step();

        // reset mid-block discards the partial sum
        put_a(24'd100, 1'b1, "t5_rdy_a");
        put_a(24'd100, 1'b1, "t5_rdy_b");
        areset = 1'b1;
        a_iv = 1'b1; a_id = 24'd100;
        step();
        chk("t5_rst_ov", {31'd0, a_ov}, 32'd0);
        chk("t5_rst_od", {8'd0, a_od}, 32'd0);
        chk("t5_rst_rdy", {31'd0, a_ir}, 32'd1);
        areset = 1'b0; a_iv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            put_a(24'd1, 1'b1, "t5_rdy");
            chk("t5_nov", {31'd0, a_ov}, 32'd0);
        end
        put_a(24'd1, 1'b1, "t5_rdy_last");
        chk("t5_ov", {31'd0, a_ov}, 32'd1);
        chk("t5_od", {8'd0, a_od}, 32'd1);
        step();
        chk("t5_drop", {31'd0, a_ov}, 32'd0);

        // random streams with random backpressure
        for (int cyc = 0; cyc < 3000; cyc++) begin
            a_iv = ($urandom_range(0, 3) != 0);
            a_id = DW'($urandom);
            a_or = ($urandom_range(0, 2) != 0);
            b_iv = ($urandom_range(0, 3) != 0);
            b_id = DW'($urandom);
            b_or = ($urandom_range(0, 2) != 0);
            #1;
            out_check();
            if (blk_n != 3) chk("rnd_a_rdy_nonfinal", {31'd0, a_ir}, 32'd1);
            if (blk_n == 3 && a_ov && !a_or) chk("rnd_a_stall", {31'd0, a_ir}, 32'd0);
            if (a_iv && a_ir) begin
                blk_sum += longint'($signed(a_id));
                blk_n++;
                if (blk_n == 4) begin
                    qa.push_back(avg4(blk_sum));
                    blk_sum = 0;
                    blk_n   = 0;
                end
            end
            if (b_iv && b_ir) qb.push_back(b_id);
            step();
        end

        a_iv = 1'b0; b_iv = 1'b0; a_or = 1'b1; b_or = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            #1;
            out_check();
            step();
        end
        chk("end_qa_empty", qa.size(), 32'd0);
        chk("end_qb_empty", qb.size(), 32'd0);
        chk("end_a_ov", {31'd0, a_ov}, 32'd0);
        chk("end_b_ov", {31'd0, b_ov}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
